// File: rtl/mem_port_sched.sv
// mem_port_sched: arbitrates the single data-memory port and its TLB between
// instruction fetch (IF) and load/store (LS). After reset it issues one TLB
// base-latch cycle. It then grants one requester per access, checks the range
// and alignment before touching memory, and returns one response per access.
//
// Handshake: a requester raises _xx_req and holds its address and data until
// xx_gnt_ is seen high in an IDLE cycle. The response (xx_rvalid_ with rdata
// and fault) is a one-cycle pulse in the following cycle. No new grant is
// given while a response is being returned, so at most one access is
// outstanding at any time.
module mem_port_sched #(
    parameter int          MEM_SLOTS_COUNT = 32,
    parameter logic [31:0] BASE_VPTR       = 32'h0000_0000
) (
    input  logic                               _clk,
    input  logic                               _reset_n,
    input  logic                               _if_req,
    input  logic [31:0]                        _if_vptr,
    output logic                               if_gnt_,
    output logic                               if_rvalid_,
    output logic [31:0]                        if_rdata_,
    output logic                               if_fault_,
    input  logic                               _ls_req,
    input  logic                               _ls_we,
    input  logic [31:0]                        _ls_vptr,
    input  logic [31:0]                        _ls_wdata,
    input  logic [3:0]                         _ls_be,
    output logic                               ls_gnt_,
    output logic                               ls_rvalid_,
    output logic [31:0]                        ls_rdata_,
    output logic                               ls_fault_,
    output logic                               tlb_init_,
    output logic [31:0]                        tlb_vptr_,
    input  logic [$clog2(MEM_SLOTS_COUNT)-1:0] _tlb_slot,
    output logic                               mem_en_,
    output logic                               mem_we_,
    output logic [3:0]                         mem_be_,
    output logic [$clog2(MEM_SLOTS_COUNT)-1:0] mem_slot_,
    output logic [31:0]                        mem_wdata_,
    input  logic [31:0]                        _mem_rdata,
    output logic [1:0]                         fsm_state_
);

    localparam int          SW   = $clog2(MEM_SLOTS_COUNT);
    localparam logic [31:0] SPAN = 32'(MEM_SLOTS_COUNT * 4);

    typedef enum logic [1:0] {
        ST_INIT = 2'd0,
        ST_IDLE = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state;
    logic        last_ls;     // 1 when the most recent grant went to LS
    logic        resp_if;
    logic        resp_ls;
    logic        resp_fault;
    logic        resp_store;

    logic        init_active;
    logic        idle;
    logic        pick_ls;
    logic        gnt_if;
    logic        gnt_ls;
    logic        granted;
    logic [31:0] sel_vptr;
    logic [31:0] off;
    logic        bad;
    logic        access;
    logic        store;

    // The base latch is gated with reset so every output reads 0 while reset is held.
    assign init_active = (state == ST_INIT) && _reset_n;
    assign idle        = (state == ST_IDLE);

    // A tie goes to LS unless LS was the last one served.
    assign pick_ls  = _ls_req && (!_if_req || !last_ls);
    assign gnt_ls   = idle && pick_ls;
    assign gnt_if   = idle && _if_req && !pick_ls;
    assign granted  = gnt_if || gnt_ls;
    assign sel_vptr = pick_ls ? _ls_vptr : _if_vptr;

    // The offset wraps, so an address below the base becomes huge and fails the range test.
    assign off    = sel_vptr - BASE_VPTR;
    assign bad    = (off[1:0] != 2'b00) || (off >= SPAN);
    assign access = granted && !bad;
    assign store  = gnt_ls && _ls_we;

    assign if_gnt_    = gnt_if;
    assign ls_gnt_    = gnt_ls;
    assign tlb_init_  = init_active;
    assign tlb_vptr_  = init_active ? BASE_VPTR : (granted ? sel_vptr : 32'h0);
    assign mem_en_    = access;
    assign mem_we_    = access && store;
    assign mem_be_    = access ? (store ? _ls_be : 4'hF) : 4'h0;
    assign mem_slot_  = access ? _tlb_slot : {SW{1'b0}};
    assign mem_wdata_ = access ? _ls_wdata : 32'h0;
    assign fsm_state_ = state;

    // The response flags are only ever set during RESP, so they double as the valid strobes.
    assign if_rvalid_ = resp_if;
    assign if_fault_  = resp_if && resp_fault;
    assign if_rdata_  = (resp_if && !resp_fault) ? _mem_rdata : 32'h0;
    assign ls_rvalid_ = resp_ls;
    assign ls_fault_  = resp_ls && resp_fault;
    assign ls_rdata_  = (resp_ls && !resp_fault && !resp_store) ? _mem_rdata : 32'h0;

    // Sequencer: one init cycle, then alternate between grant (IDLE) and response (RESP).
    always_ff @(posedge _clk or negedge _reset_n) begin
        if (!_reset_n) begin
            state      <= ST_INIT;
            last_ls    <= 1'b0;
            resp_if    <= 1'b0;
            resp_ls    <= 1'b0;
            resp_fault <= 1'b0;
            resp_store <= 1'b0;
        end else begin
            case (state)
                ST_INIT: state <= ST_IDLE;
                ST_IDLE: begin
                    if (granted) begin
                        state      <= ST_RESP;
                        last_ls    <= gnt_ls;
                        resp_if    <= gnt_if;
                        resp_ls    <= gnt_ls;
                        resp_fault <= bad;
                        resp_store <= store;
                    end
                end
                ST_RESP: begin
                    state      <= ST_IDLE;
                    resp_if    <= 1'b0;
                    resp_ls    <= 1'b0;
                    resp_fault <= 1'b0;
                    resp_store <= 1'b0;
                end
                default: state <= ST_INIT;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_sched.sv
// Bench for mem_port_sched: the bench provides small TLB and slot-memory
// models, directed driver tasks, and a response monitor that pops expected
// {fault, rdata} entries from per-requester queues.
module tb_mem_port_sched;

    localparam int          SLOTS = 32;
    localparam int          SW    = 5;
    localparam logic [31:0] BASE  = 32'h0000_1000;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic          if_req = 1'b0;
    logic [31:0]   if_vptr = '0;
    logic          if_gnt, if_rvalid, if_fault;
    logic [31:0]   if_rdata;
    logic          ls_req = 1'b0;
    logic          ls_we = 1'b0;
    logic [31:0]   ls_vptr = '0;
    logic [31:0]   ls_wdata = '0;
    logic [3:0]    ls_be = '0;
    logic          ls_gnt, ls_rvalid, ls_fault;
    logic [31:0]   ls_rdata;
    logic          tlb_init;
    logic [31:0]   tlb_vptr;
    logic [SW-1:0] tlb_slot;
    logic          mem_en, mem_we;
    logic [3:0]    mem_be;
    logic [SW-1:0] mem_slot;
    logic [31:0]   mem_wdata;
    logic [31:0]   mem_rdata = '0;
    logic [1:0]    fsm_state;

    mem_port_sched #(.MEM_SLOTS_COUNT(SLOTS), .BASE_VPTR(BASE)) dut (
        ._clk(clk), ._reset_n(rst_n),
        ._if_req(if_req), ._if_vptr(if_vptr), .if_gnt_(if_gnt),
        .if_rvalid_(if_rvalid), .if_rdata_(if_rdata), .if_fault_(if_fault),
        ._ls_req(ls_req), ._ls_we(ls_we), ._ls_vptr(ls_vptr), ._ls_wdata(ls_wdata),
        ._ls_be(ls_be), .ls_gnt_(ls_gnt), .ls_rvalid_(ls_rvalid), .ls_rdata_(ls_rdata),
        .ls_fault_(ls_fault), .tlb_init_(tlb_init), .tlb_vptr_(tlb_vptr),
        ._tlb_slot(tlb_slot), .mem_en_(mem_en), .mem_we_(mem_we), .mem_be_(mem_be),
        .mem_slot_(mem_slot), .mem_wdata_(mem_wdata), ._mem_rdata(mem_rdata),
        .fsm_state_(fsm_state)
    );

    // ---------------- TLB and memory models ----------------
    logic [31:0] tlb_base = '0;
    logic [31:0] mem [SLOTS];
    logic [31:0] tlb_off;

    assign tlb_off  = tlb_vptr - tlb_base;
    assign tlb_slot = tlb_off[SW+1:2];

    initial begin
        for (int i = 0; i < SLOTS; i++) mem[i] = 32'h0;
    end

    always @(posedge clk) begin
        if (tlb_init) tlb_base <= tlb_vptr;
        if (mem_en) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) mem[mem_slot][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= mem[mem_slot];
            end
        end
    end

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [32:0] exp_if_q[$];
    logic [32:0] exp_ls_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic do_ls(input logic we, input logic [31:0] vptr, input logic [31:0] wdata,
                         input logic [3:0] be, input logic exp_fault, input logic [SW-1:0] exp_slot,
                         input logic [31:0] exp_rdata, input bit push);
        bit got = 1'b0;
        ls_req = 1'b1; ls_we = we; ls_vptr = vptr; ls_wdata = wdata; ls_be = be;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (ls_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL ls_grant_timeout: no ls grant for vptr %h", vptr);
        end else begin
            chk("ls_if_gnt_quiet", 32'(if_gnt), 32'h0);
            chk("ls_mem_en", 32'(mem_en), 32'(!exp_fault));
            chk("ls_mem_we", 32'(mem_we), 32'(we && !exp_fault));
            chk("ls_mem_be", 32'(mem_be), exp_fault ? 32'h0 : (we ? 32'(be) : 32'hF));
            chk("ls_tlb_vptr", tlb_vptr, vptr);
            if (!exp_fault) chk("ls_mem_slot", 32'(mem_slot), 32'(exp_slot));
            if (push) exp_ls_q.push_back({exp_fault, exp_rdata});
        end
        @(posedge clk); #1;
        ls_req = 1'b0;
    endtask

    task automatic do_if(input logic [31:0] vptr, input logic exp_fault,
                         input logic [SW-1:0] exp_slot, input logic [31:0] exp_rdata);
        bit got = 1'b0;
        if_req = 1'b1; if_vptr = vptr;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (if_gnt) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) begin
            checks++; errors++;
            $display("FAIL if_grant_timeout: no if grant for vptr %h", vptr);
        end else begin
            chk("if_ls_gnt_quiet", 32'(ls_gnt), 32'h0);
            chk("if_mem_en", 32'(mem_en), 32'(!exp_fault));
            chk("if_mem_we", 32'(mem_we), 32'h0);
            if (!exp_fault) chk("if_mem_slot", 32'(mem_slot), 32'(exp_slot));
            exp_if_q.push_back({exp_fault, exp_rdata});
        end
        @(posedge clk); #1;
        if_req = 1'b0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence + monitor ----------------
    initial begin
        // Monitor: every response pulse must match the oldest expected entry.
        fork
            forever begin
                @(negedge clk);
                if (if_rvalid) begin
                    if (exp_if_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL if_unexpected_rvalid: got fault=%b rdata=%h expected none", if_fault, if_rdata);
                    end else begin
                        chk("if_resp", {31'h0, if_fault} ^ 32'h0, 32'(exp_if_q[0][32]));
                        chk("if_rdata", if_rdata, exp_if_q[0][31:0]);
                        void'(exp_if_q.pop_front());
                    end
                end
                if (ls_rvalid) begin
                    if (exp_ls_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL ls_unexpected_rvalid: got fault=%b rdata=%h expected none", ls_fault, ls_rdata);
                    end else begin
                        chk("ls_fault", 32'(ls_fault), 32'(exp_ls_q[0][32]));
                        chk("ls_rdata", ls_rdata, exp_ls_q[0][31:0]);
                        void'(exp_ls_q.pop_front());
                    end
                end
            end
        join_none

        // 1: reset, then exactly one init cycle
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_tlb_init", 32'(tlb_init), 32'h0);
        chk("rst_tlb_vptr", tlb_vptr, 32'h0);
        chk("rst_mem_en", 32'(mem_en), 32'h0);
        chk("rst_rvalid", 32'({if_rvalid, ls_rvalid}), 32'h0);
        chk("rst_state", 32'(fsm_state), 32'h0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("init_tlb_init", 32'(tlb_init), 32'h1);
        chk("init_tlb_vptr", tlb_vptr, BASE);
        chk("init_no_gnt", 32'({if_gnt, ls_gnt}), 32'h0);
        @(negedge clk);
        chk("idle_tlb_init", 32'(tlb_init), 32'h0);
        chk("idle_tlb_vptr", tlb_vptr, 32'h0);
        chk("idle_state", 32'(fsm_state), 32'h1);
        @(posedge clk); #1;

        // 2: store then fetch the same word
        do_ls(1'b1, 32'h1008, 32'hDEADBEEF, 4'hF, 1'b0, 5'd2, 32'h0, 1'b1);
        do_if(32'h1008, 1'b0, 5'd2, 32'hDEADBEEF);

        // 3: both requesting every cycle; last grant was IF so LS wins first
        repeat (2) @(posedge clk);
        #1;
        if_req = 1'b1; if_vptr = 32'h1008;
        ls_req = 1'b1; ls_we = 1'b0; ls_vptr = 32'h1008; ls_be = 4'h0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("rr_ls_gnt", 32'(ls_gnt), 32'((i % 4) == 0));
            chk("rr_if_gnt", 32'(if_gnt), 32'((i % 4) == 2));
            if ((i % 4) == 0) exp_ls_q.push_back({1'b0, 32'hDEADBEEF});
            if ((i % 4) == 2) exp_if_q.push_back({1'b0, 32'hDEADBEEF});
        end
        @(posedge clk); #1;
        if_req = 1'b0; ls_req = 1'b0;

        // 4: faults (misaligned, past end, below base) and last valid slot
        do_ls(1'b0, 32'h1006, 32'h0, 4'h0, 1'b1, 5'd0, 32'h0, 1'b1);
        do_ls(1'b0, 32'h1080, 32'h0, 4'h0, 1'b1, 5'd0, 32'h0, 1'b1);
        do_ls(1'b0, 32'h0FFC, 32'h0, 4'h0, 1'b1, 5'd0, 32'h0, 1'b1);
        do_if(32'h1002, 1'b1, 5'd0, 32'h0);
        do_ls(1'b1, 32'h107C, 32'h12345678, 4'hF, 1'b0, 5'd31, 32'h0, 1'b1);
        do_ls(1'b0, 32'h107C, 32'h0, 4'h0, 1'b0, 5'd31, 32'h12345678, 1'b1);

        // 5: partial store, then read back the merged word
        do_ls(1'b1, 32'h1010, 32'hA5A5A5A5, 4'b0011, 1'b0, 5'd4, 32'h0, 1'b1);
        do_ls(1'b0, 32'h1010, 32'h0, 4'h0, 1'b0, 5'd4, 32'h0000A5A5, 1'b1);

        // 6: reset during RESP drops the response and re-runs init
        do_ls(1'b0, 32'h1008, 32'h0, 4'h0, 1'b0, 5'd2, 32'hDEADBEEF, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("midrst_ls_rvalid", 32'(ls_rvalid), 32'h0);
        chk("midrst_ls_rdata", ls_rdata, 32'h0);
        chk("midrst_state", 32'(fsm_state), 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reinit_tlb_init", 32'(tlb_init), 32'h1);
        chk("reinit_tlb_vptr", tlb_vptr, BASE);
        @(negedge clk);
        chk("reinit_done", 32'(tlb_init), 32'h0);
        @(posedge clk); #1;
        do_if(32'h1008, 1'b0, 5'd2, 32'hDEADBEEF);

        repeat (4) @(negedge clk);
        chk("if_queue_drained", 32'(exp_if_q.size()), 32'h0);
        chk("ls_queue_drained", 32'(exp_ls_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
